// File: rtl/wb_mem_slave.sv
// Purpose : Wishbone B4 pipelined slave, REGISTER_NUM flop words with byte-lane writes.
// Latency : WAIT_CYCLES+1 cycles from accept to ack_o/err_o.
// Backpr. : stall_o high for WAIT_CYCLES cycles after each accept; zero stall when WAIT_CYCLES=0.
//
// Ports: clk_i/rst_i (async active-low) ; adr_i/dat_i/sel_i/we_i/stb_i/cyc_i request
// from the master ; dat_o read data, ack_o/err_o one-cycle terminations, stall_o.
// All outputs are registered.
module wb_mem_slave #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int GRANULE      = 8,
    parameter int REGISTER_NUM = 16,
    parameter int WAIT_CYCLES  = 0,
    parameter int SEL_WIDTH    = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  we_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    // Counter is at least one bit so the W=0 build still has a legal vector.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  we_q;

    logic [DATA_WIDTH-1:0] mem [REGISTER_NUM];

    logic                  accept;
    logic                  wait_done;
    logic                  do_access;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic [SEL_WIDTH-1:0]  acc_sel;
    logic                  acc_we;
    logic                  addr_bad;

    assign accept    = (state == ST_IDLE) && cyc_i && stb_i && !stall_o;
    // Dropping cyc_i in the last wait cycle still aborts: abort wins over completion.
    assign wait_done = (state == ST_WAIT) && cyc_i && (cnt == CNT_LAST);
    assign do_access = (accept && NO_WAIT) || wait_done;

    // Zero-wait accesses use the live bus; waited accesses use the copy taken at accept.
    assign acc_adr = (state == ST_IDLE) ? adr_i : adr_q;
    assign acc_dat = (state == ST_IDLE) ? dat_i : dat_q;
    assign acc_sel = (state == ST_IDLE) ? sel_i : sel_q;
    assign acc_we  = (state == ST_IDLE) ? we_i  : we_q;

    assign addr_bad = (32'(acc_adr) >= 32'(REGISTER_NUM));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            stall_o <= 1'b0;
            dat_o   <= '0;
            for (int i = 0; i < REGISTER_NUM; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        adr_q <= adr_i;
                        dat_q <= dat_i;
                        sel_q <= sel_i;
                        we_q  <= we_i;
                        if (!NO_WAIT) begin
                            state   <= ST_WAIT;
                            stall_o <= 1'b1;
                            cnt     <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cyc_i || (cnt == CNT_LAST)) begin
                        state   <= ST_IDLE;
                        stall_o <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    stall_o <= 1'b0;
                    cnt     <= '0;
                end
            endcase

            if (do_access) begin
                if (addr_bad) begin
                    err_o <= 1'b1;
                    dat_o <= '0;
                end else begin
                    ack_o <= 1'b1;
                    if (acc_we) begin
                        for (int k = 0; k < SEL_WIDTH; k++) begin
                            if (acc_sel[k]) begin
                                mem[acc_adr][GRANULE*k +: GRANULE] <= acc_dat[GRANULE*k +: GRANULE];
                            end
                        end
                    end else begin
                        dat_o <= mem[acc_adr];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: four instances cover W=0, W=2, REGISTER_NUM=12 and W=3.
module tb_wb_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [4];
    logic [3:0]  adr   [4];
    logic [31:0] wdat  [4];
    logic [31:0] rdat  [4];
    logic [3:0]  sel   [4];
    logic        we    [4];
    logic        stb   [4];
    logic        cyc   [4];
    logic        ack   [4];
    logic        err   [4];
    logic        stall [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_mem_slave #(
            .ADDR_WIDTH  (4),
            .DATA_WIDTH  (32),
            .GRANULE     (8),
            .REGISTER_NUM(g == 2 ? 12 : 16),
            .WAIT_CYCLES (g == 1 ? 2 : (g == 3 ? 3 : 0))
        ) u_dut (
            .clk_i  (clk),
            .rst_i  (rst_n[g]),
            .adr_i  (adr[g]),
            .dat_i  (wdat[g]),
            .dat_o  (rdat[g]),
            .sel_i  (sel[g]),
            .we_i   (we[g]),
            .stb_i  (stb[g]),
            .cyc_i  (cyc[g]),
            .ack_o  (ack[g]),
            .err_o  (err[g]),
            .stall_o(stall[g])
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [4][16];
    logic        ga, ge;
    logic [31:0] gd;
    int          lat;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; wdat[g] = d; sel[g] = s;
    endtask

    // One request, then wait (bounded) for its termination; lat counts edges from accept.
    task automatic xfer(input int g, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic o_ack, output logic o_err, output logic [31:0] o_dat,
                        output int o_lat);
        drive(g, w, a, d, s);
        tick();
        stb[g] = 1'b0;
        o_lat = 1;
        while (!(ack[g] || err[g]) && o_lat < 20) begin
            tick();
            o_lat++;
        end
        o_ack = ack[g]; o_err = err[g]; o_dat = rdat[g];
        cyc[g] = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 4; g++) begin
            rst_n[g] = 1'b0; cyc[g] = 0; stb[g] = 0; we[g] = 0; adr[g] = 0; wdat[g] = 0; sel[g] = 0;
            for (int i = 0; i < 16; i++) model[g][i] = '0;
        end
        tick(); tick(); tick();
        for (int g = 0; g < 4; g++) begin
            n_checks++; if (ack[g] !== 1'b0)   begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", g, ack[g]); end
            n_checks++; if (err[g] !== 1'b0)   begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", g, err[g]); end
            n_checks++; if (stall[g] !== 1'b0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %b want 0", g, stall[g]); end
            n_checks++; if (rdat[g] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d]: got %h want 0", g, rdat[g]); end
            rst_n[g] = 1'b1;
        end
        tick();
        xfer(0, 1'b0, 4'd3, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (ga !== 1'b1)  begin n_fail++; $display("FAIL reset_read_ack: got %b want 1", ga); end
        n_checks++; if (lat != 1)     begin n_fail++; $display("FAIL reset_read_lat: got %0d want 1", lat); end
        n_checks++; if (gd !== 32'h0) begin n_fail++; $display("FAIL reset_read_dat: got %h want 0", gd); end
    endtask

    task automatic test_byte_lanes();
        xfer(0, 1'b1, 4'd5, 32'hAABBCCDD, 4'b1111, ga, ge, gd, lat);
        model[0][5] = merge(model[0][5], 32'hAABBCCDD, 4'b1111);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL lanes_wr1_ack: got %b want 1", ga); end
        xfer(0, 1'b1, 4'd5, 32'h11223344, 4'b0101, ga, ge, gd, lat);
        model[0][5] = merge(model[0][5], 32'h11223344, 4'b0101);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL lanes_wr2_ack: got %b want 1", ga); end
        xfer(0, 1'b0, 4'd5, 32'h0, 4'b0001, ga, ge, gd, lat);
        n_checks++; if (gd !== 32'hAA22CC44) begin n_fail++; $display("FAIL lanes_read: got %h want AA22CC44", gd); end
        n_checks++; if (gd !== model[0][5]) begin n_fail++; $display("FAIL lanes_model: got %h want %h", gd, model[0][5]); end
    endtask

    task automatic test_back_to_back();
        logic        w_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  a_t [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [31:0] d_t [4] = '{32'd1, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive(0, w_t[i], a_t[i], d_t[i], 4'hF);
            tick();
            n_checks++; if (ack[0] !== 1'b1)  begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ack[0]); end
            n_checks++; if (stall[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, stall[0]); end
            if (w_t[i]) model[0][a_t[i]] = d_t[i];
            else begin
                n_checks++;
                if (rdat[0] !== 32'(a_t[i] + 1)) begin n_fail++; $display("FAIL b2b_read[%0d]: got %h want %h", i, rdat[0], a_t[i] + 1); end
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ack: got %b want 0", ack[0]); end
    endtask

    task automatic test_random_pipelined();
        logic [31:0] exp_dat;
        xfer(0, 1'b0, 4'd0, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (gd !== model[0][0]) begin n_fail++; $display("FAIL rnd_seed_read: got %h want %h", gd, model[0][0]); end
        exp_dat = model[0][0];
        for (int i = 0; i < 200; i++) begin
            logic go, w; logic [3:0] a, s; logic [31:0] d;
            go = ($urandom_range(0, 3) != 0); w = 1'($urandom); a = 4'($urandom);
            s = 4'($urandom); d = $urandom;
            drive(0, w, a, d, s);
            stb[0] = go;
            tick();
            if (go) begin
                if (w) model[0][a] = merge(model[0][a], d, s);
                else   exp_dat = model[0][a];
            end
            n_checks++; if (ack[0] !== go)     begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, ack[0], go); end
            n_checks++; if (err[0] !== 1'b0)   begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want 0", i, err[0]); end
            n_checks++; if (stall[0] !== 1'b0) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want 0", i, stall[0]); end
            n_checks++; if (rdat[0] !== exp_dat) begin n_fail++; $display("FAIL rnd_dat[%0d]: got %h want %h", i, rdat[0], exp_dat); end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        logic [31:0] v4, v9;
        v4 = $urandom; v9 = $urandom;
        xfer(1, 1'b1, 4'd4, v4, 4'hF, ga, ge, gd, lat); model[1][4] = v4;
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL ws_wr_lat: got %0d want 3", lat); end
        xfer(1, 1'b1, 4'd9, v9, 4'hF, ga, ge, gd, lat); model[1][9] = v9;
        drive(1, 1'b0, 4'd4, 32'h0, 4'hF);
        tick();
        n_checks++; if (stall[1] !== 1'b1) begin n_fail++; $display("FAIL ws_stall_n1: got %b want 1", stall[1]); end
        n_checks++; if (ack[1] !== 1'b0)   begin n_fail++; $display("FAIL ws_ack_n1: got %b want 0", ack[1]); end
        drive(1, 1'b0, 4'd9, 32'h0, 4'hF);
        tick();
        n_checks++; if (stall[1] !== 1'b1) begin n_fail++; $display("FAIL ws_stall_n2: got %b want 1", stall[1]); end
        n_checks++; if (ack[1] !== 1'b0)   begin n_fail++; $display("FAIL ws_ack_n2: got %b want 0", ack[1]); end
        tick();
        n_checks++; if (ack[1] !== 1'b1)   begin n_fail++; $display("FAIL ws_ack_n3: got %b want 1", ack[1]); end
        n_checks++; if (stall[1] !== 1'b0) begin n_fail++; $display("FAIL ws_stall_n3: got %b want 0", stall[1]); end
        n_checks++; if (rdat[1] !== v4)    begin n_fail++; $display("FAIL ws_dat_n3: got %h want %h", rdat[1], v4); end
        tick();
        stb[1] = 1'b0;
        n_checks++; if (stall[1] !== 1'b1) begin n_fail++; $display("FAIL ws_stall_n4: got %b want 1", stall[1]); end
        n_checks++; if (ack[1] !== 1'b0)   begin n_fail++; $display("FAIL ws_ack_n4: got %b want 0", ack[1]); end
        tick();
        n_checks++; if (ack[1] !== 1'b0)   begin n_fail++; $display("FAIL ws_ack_n5: got %b want 0", ack[1]); end
        tick();
        n_checks++; if (ack[1] !== 1'b1)   begin n_fail++; $display("FAIL ws_ack_n6: got %b want 1", ack[1]); end
        n_checks++; if (rdat[1] !== v9)    begin n_fail++; $display("FAIL ws_dat_n6: got %h want %h", rdat[1], v9); end
        cyc[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic w; logic [3:0] a, s; logic [31:0] d;
            w = 1'($urandom); a = 4'($urandom); s = 4'($urandom); d = $urandom;
            xfer(1, w, a, d, s, ga, ge, gd, lat);
            n_checks++; if (lat != 3 || ga !== 1'b1 || ge !== 1'b0) begin n_fail++; $display("FAIL ws_rnd_term[%0d]: got lat %0d ack %b err %b want 3 1 0", i, lat, ga, ge); end
            if (w) model[1][a] = merge(model[1][a], d, s);
            else begin
                n_checks++; if (gd !== model[1][a]) begin n_fail++; $display("FAIL ws_rnd_dat[%0d]: got %h want %h", i, gd, model[1][a]); end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] v;
        v = $urandom;
        xfer(2, 1'b1, 4'd11, v, 4'hF, ga, ge, gd, lat);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL err_wr11_ack: got %b want 1", ga); end
        xfer(2, 1'b1, 4'd13, 32'hCAFEF00D, 4'hF, ga, ge, gd, lat);
        n_checks++; if (ge !== 1'b1) begin n_fail++; $display("FAIL err_wr13_err: got %b want 1", ge); end
        n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL err_wr13_ack: got %b want 0", ga); end
        xfer(2, 1'b0, 4'd11, 32'h0, 4'hF, ga, ge, gd, lat);
        xfer(2, 1'b0, 4'd13, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (ge !== 1'b1 || ga !== 1'b0) begin n_fail++; $display("FAIL err_rd13_term: got err %b ack %b want 1 0", ge, ga); end
        n_checks++; if (gd !== 32'h0) begin n_fail++; $display("FAIL err_rd13_dat: got %h want 0", gd); end
        xfer(2, 1'b0, 4'd11, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (ga !== 1'b1 || ge !== 1'b0) begin n_fail++; $display("FAIL err_rd11_term: got ack %b err %b want 1 0", ga, ge); end
        n_checks++; if (gd !== v) begin n_fail++; $display("FAIL err_rd11_dat: got %h want %h", gd, v); end
    endtask

    task automatic test_abort_reset();
        logic [31:0] old, v7;
        old = $urandom; v7 = $urandom | 32'h1;
        xfer(3, 1'b1, 4'd2, old, 4'hF, ga, ge, gd, lat); model[3][2] = old;
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ab_wr_lat: got %0d want 4", lat); end
        xfer(3, 1'b1, 4'd7, v7, 4'hF, ga, ge, gd, lat); model[3][7] = v7;
        // Abort: cyc_i dropped during the second wait cycle.
        drive(3, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF);
        tick();
        stb[3] = 1'b0;
        n_checks++; if (stall[3] !== 1'b1) begin n_fail++; $display("FAIL ab_stall_w1: got %b want 1", stall[3]); end
        tick();
        cyc[3] = 1'b0;
        tick();
        n_checks++; if (stall[3] !== 1'b0) begin n_fail++; $display("FAIL ab_stall_drop: got %b want 0", stall[3]); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ack[3] !== 1'b0 || err[3] !== 1'b0) begin n_fail++; $display("FAIL ab_no_term[%0d]: got ack %b err %b want 0 0", i, ack[3], err[3]); end
            tick();
        end
        xfer(3, 1'b0, 4'd2, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (gd !== old || lat != 4) begin n_fail++; $display("FAIL ab_read_old: got %h lat %0d want %h lat 4", gd, lat, old); end
        // Reset in the middle of a waited write.
        drive(3, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF);
        tick();
        stb[3] = 1'b0;
        tick();
        rst_n[3] = 1'b0; cyc[3] = 1'b0;
        #1;
        n_checks++; if (ack[3] !== 1'b0 || err[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_term: got ack %b err %b want 0 0", ack[3], err[3]); end
        n_checks++; if (stall[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall[3]); end
        n_checks++; if (rdat[3] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dat: got %h want 0", rdat[3]); end
        tick();
        rst_n[3] = 1'b1;
        for (int i = 0; i < 16; i++) model[3][i] = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (ack[3] !== 1'b0 || err[3] !== 1'b0 || stall[3] !== 1'b0) begin n_fail++; $display("FAIL rst_after[%0d]: got ack %b err %b stall %b want 0 0 0", i, ack[3], err[3], stall[3]); end
        end
        xfer(3, 1'b0, 4'd2, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (gd !== model[3][2] || ga !== 1'b1 || lat != 4) begin n_fail++; $display("FAIL rst_clr2: got %h ack %b lat %0d want 0 1 4", gd, ga, lat); end
        xfer(3, 1'b0, 4'd7, 32'h0, 4'hF, ga, ge, gd, lat);
        n_checks++; if (gd !== model[3][7]) begin n_fail++; $display("FAIL rst_clr7: got %h want 0", gd); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_random_pipelined();
        test_wait_states();
        test_error();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
